// File: rtl/regfile_wport_arb_pkg.sv
// Shared constants and types for the regfile write-port arbiter.
// Holds the regfile bus widths, reset/write-enable encodings and the r0 helper.
package regfile_wport_arb_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
  localparam logic                  WRITE_ENABLE  = 1'b1;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic                  RST_ENABLE    = 1'b1;
  localparam logic                  STOP          = 1'b1;
  localparam logic                  NO_STOP       = 1'b0;

  // r0 is hardwired to zero, so writes to it are swallowed here
  function automatic logic writes_r0(input logic [REG_ADDR_W-1:0] addr);
    return addr == NOP_REG_ADDR;
  endfunction

endpackage

// File: rtl/regfile_wport_arb_starve_cnt.sv
// Saturating wait counter for port 1 plus the registered stall request.
// The counter restarts whenever port 1 is accepted or withdraws its request.
module regfile_wport_arb_starve_cnt
  import regfile_wport_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic wb1_valid,
  input  logic wb1_ready,
  output logic stallreq
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stallreq_q, stallreq_d;
  logic             waiting;

  assign waiting = wb1_valid && !wb1_ready;

  always_comb begin
    cnt_d      = '0;
    stallreq_d = NO_STOP;
    if (waiting) begin
      cnt_d = (cnt_q == CNT_W'(STARVE_MAX)) ? cnt_q : cnt_q + 1'b1;
      // Saturation keeps the request asserted while port 1 is still blocked
      stallreq_d = (cnt_d == CNT_W'(STARVE_MAX)) ? STOP : NO_STOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt_q      <= '0;
      stallreq_q <= NO_STOP;
    end else begin
      cnt_q      <= cnt_d;
      stallreq_q <= stallreq_d;
    end
  end

  assign stallreq = stallreq_q;

endmodule

// File: rtl/regfile_wport_arb.sv
// Fixed-priority arbiter for the regfile's single write port.
// Pipeline writeback always wins; the multi-cycle source is protected by a stall request.
module regfile_wport_arb
  import regfile_wport_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_we,
  input  logic [REG_ADDR_W-1:0] wb0_waddr,
  input  logic [REG_W-1:0]      wb0_wdata,
  input  logic                  wb1_valid,
  input  logic [REG_ADDR_W-1:0] wb1_waddr,
  input  logic [REG_W-1:0]      wb1_wdata,
  output logic                  wb1_ready,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [REG_W-1:0]      wdata,
  output logic                  stallreq
);

  logic                  grant0;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [REG_W-1:0]      wdata_q, wdata_d;

  assign grant0    = wb0_we;
  assign wb1_ready = wb1_valid && !wb0_we && (rst != RST_ENABLE);

  always_comb begin
    we_d    = WRITE_DISABLE;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant0) begin
      we_d    = !writes_r0(wb0_waddr);
      waddr_d = wb0_waddr;
      wdata_d = wb0_wdata;
    end else if (wb1_ready) begin
      we_d    = !writes_r0(wb1_waddr);
      waddr_d = wb1_waddr;
      wdata_d = wb1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      we_q    <= WRITE_DISABLE;
      waddr_q <= NOP_REG_ADDR;
      wdata_q <= ZERO_WORD;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  regfile_wport_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .wb1_valid(wb1_valid),
    .wb1_ready(wb1_ready),
    .stallreq (stallreq)
  );

endmodule
